// File: rtl/dcache_axi_burst_arb.sv
// ----------------------------------------------------------------------------
// dcache_axi_burst_arb
//   Shares one data-cache memory port between NUM_REQ burst requesters
//   (refill, writeback, uncached). Round-robin arbitration in IDLE, grant
//   locked for the whole burst, write/read beats counted against the
//   request length, port released only once the burst has completed.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   req_valid_i/write_i    per-requester command valid / direction
//   req_addr_i/len_i       packed per-requester address / length (beats-1)
//   req_accept_o           one-hot command accept (IDLE cycle of the pick)
//   req_wvalid_i           per-requester write beat valid
//   req_waccept_o          write beat accepted, grantee only
//   req_done_o             one-hot burst completion pulse
//   grant_o                current owner, one-hot, zero when idle
//   outport_*              command / write-beat / response side to the bridge
// ----------------------------------------------------------------------------
module dcache_axi_burst_arb #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
    output logic [NUM_REQ-1:0]        req_accept_o,
    input  logic [NUM_REQ-1:0]        req_wvalid_i,
    output logic [NUM_REQ-1:0]        req_waccept_o,
    output logic [NUM_REQ-1:0]        req_done_o,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      outport_valid_o,
    output logic                      outport_write_o,
    output logic [ADDR_W-1:0]         outport_addr_o,
    output logic [LEN_W-1:0]          outport_len_o,
    input  logic                      outport_accept_i,
    output logic                      outport_wvalid_o,
    input  logic                      outport_waccept_i,
    input  logic                      outport_rvalid_i,
    input  logic                      outport_bvalid_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WDATA,
        S_WRESP,
        S_RDATA
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;
    logic [LEN_W-1:0]   beat_cnt;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               wvalid_g;
    logic               beat_ok;
    logic               done_now;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign wvalid_g = req_wvalid_i[grant_idx];
    assign beat_ok  = (state == S_WDATA) && wvalid_g && outport_waccept_i;
    assign done_now = ((state == S_WRESP) && outport_bvalid_i) ||
                      ((state == S_RDATA) && outport_rvalid_i && (beat_cnt == '0));

    // Accept is gated by reset so a requester never sees a pick the FSM
    // cannot take while reset is held.
    assign req_accept_o     = ((state == S_IDLE) && rst_ni && pick_found) ? onehot(pick_idx) : '0;
    assign req_waccept_o    = beat_ok ? grant_o : '0;
    assign req_done_o       = done_now ? grant_o : '0;
    assign outport_valid_o  = (state == S_ISSUE);
    assign outport_wvalid_o = (state == S_WDATA) && wvalid_g;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= S_IDLE;
            rr_ptr          <= '0;
            grant_idx       <= '0;
            grant_o         <= '0;
            beat_cnt        <= '0;
            outport_addr_o  <= '0;
            outport_len_o   <= '0;
            outport_write_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_o         <= onehot(pick_idx);
                        grant_idx       <= pick_idx;
                        outport_addr_o  <= req_addr_i[pick_idx*ADDR_W +: ADDR_W];
                        outport_len_o   <= req_len_i[pick_idx*LEN_W +: LEN_W];
                        outport_write_o <= req_write_i[pick_idx];
                        state           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (outport_accept_i) begin
                        beat_cnt <= outport_len_o;
                        state    <= outport_write_o ? S_WDATA : S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (beat_ok) begin
                        if (beat_cnt != '0) beat_cnt <= beat_cnt - 1'b1;
                        else                state    <= S_WRESP;
                    end
                end
                S_RDATA: begin
                    if (outport_rvalid_i && (beat_cnt != '0))
                        beat_cnt <= beat_cnt - 1'b1;
                end
                default: ;
            endcase

            // Completion from either RDATA or WRESP releases the port.
            if (done_now) begin
                grant_o <= '0;
                rr_ptr  <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                state   <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dcache_axi_burst_arb.sv
module tb_dcache_axi_burst_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_write_i;
    logic [63:0] req_addr_i;
    logic [15:0] req_len_i;
    logic [1:0]  req_accept_o;
    logic [1:0]  req_wvalid_i;
    logic [1:0]  req_waccept_o;
    logic [1:0]  req_done_o;
    logic [1:0]  grant_o;
    logic        outport_valid_o;
    logic        outport_write_o;
    logic [31:0] outport_addr_o;
    logic [7:0]  outport_len_o;
    logic        outport_accept_i;
    logic        outport_wvalid_o;
    logic        outport_waccept_i;
    logic        outport_rvalid_i;
    logic        outport_bvalid_i;

    logic [31:0] addr_a [2];
    logic [7:0]  len_a  [2];
    logic        wr_a   [2];
    int          rr;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign req_addr_i  = {addr_a[1], addr_a[0]};
    assign req_len_i   = {len_a[1], len_a[0]};
    assign req_write_i = {wr_a[1], wr_a[0]};

    always #5 clk_i = ~clk_i;

    dcache_axi_burst_arb #(.NUM_REQ(2), .ADDR_W(32), .LEN_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .req_accept_o(req_accept_o), .req_wvalid_i(req_wvalid_i),
        .req_waccept_o(req_waccept_o), .req_done_o(req_done_o), .grant_o(grant_o),
        .outport_valid_o(outport_valid_o), .outport_write_o(outport_write_o),
        .outport_addr_o(outport_addr_o), .outport_len_o(outport_len_o),
        .outport_accept_i(outport_accept_i), .outport_wvalid_o(outport_wvalid_o),
        .outport_waccept_i(outport_waccept_i), .outport_rvalid_i(outport_rvalid_i),
        .outport_bvalid_i(outport_bvalid_i)
    );

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_reqs(input int maxlen);
        for (int i = 0; i < 2; i++) begin
            addr_a[i] = $urandom;
            len_a[i]  = 8'($urandom_range(0, maxlen));
            wr_a[i]   = 1'($urandom);
        end
    endtask

    // One complete burst, bench acting as requesters and bridge.
    // mode 0: random handshakes; mode 1: every beat offered, write accept
    // pattern 1,0,1,1 then 1s, three idle cycles before bvalid.
    // abort: reset is applied right after the command is accepted.
    task automatic serve(input logic [1:0] valids, input bit keep, input int mode,
                         input int issue_wait, input bit abort);
        int          w;
        int          n;
        int          acc;
        int          guard;
        int          blen;
        logic        wv;
        logic        wa;
        logic        rv;
        logic [1:0]  oh;
        logic [1:0]  exp_done;
        logic [3:0]  pat;
        pat = 4'b1101;
        w = -1;
        for (int k = 0; k < 2; k++)
            if (w < 0 && valids[(rr + k) % 2]) w = (rr + k) % 2;
        oh = '0;
        oh[w] = 1'b1;
        blen = int'(len_a[w]) + 1;

        // IDLE: arbitration decision
        req_valid_i = valids; req_wvalid_i = '0; outport_accept_i = 1'b0;
        outport_waccept_i = 1'b0; outport_rvalid_i = 1'b0; outport_bvalid_i = 1'b0;
        #2;
        n_checks++;
        if (req_accept_o !== oh) begin n_fail++; $display("FAIL accept: got %b want %b", req_accept_o, oh); end
        n_checks++;
        if (grant_o !== 2'b00 || req_done_o !== 2'b00) begin
            n_fail++; $display("FAIL idle_grant: grant %b done %b want 00/00", grant_o, req_done_o);
        end
        next_cycle();
        if (!keep) req_valid_i[w] = 1'b0;

        // ISSUE: fields stable, strays ignored, no write beats forwarded
        n = (issue_wait < 0) ? $urandom_range(0, 3) : issue_wait;
        for (int c = 0; c <= n; c++) begin
            outport_accept_i = (c == n);
            outport_rvalid_i = 1'($urandom); outport_bvalid_i = 1'($urandom);
            outport_waccept_i = 1'($urandom); req_wvalid_i = 2'b11;
            #2;
            n_checks++;
            if (outport_valid_o !== 1'b1 || outport_addr_o !== addr_a[w] ||
                outport_len_o !== len_a[w] || outport_write_o !== wr_a[w]) begin
                n_fail++;
                $display("FAIL issue_cmd: v=%b a=%h l=%0d w=%b want 1 %h %0d %b", outport_valid_o,
                         outport_addr_o, outport_len_o, outport_write_o, addr_a[w], len_a[w], wr_a[w]);
            end
            n_checks++;
            if (grant_o !== oh || outport_wvalid_o !== 1'b0 || req_waccept_o !== 2'b00 ||
                req_done_o !== 2'b00 || req_accept_o !== 2'b00) begin
                n_fail++;
                $display("FAIL issue_side: grant=%b wv=%b wa=%b done=%b acc=%b want %b 0 00 00 00",
                         grant_o, outport_wvalid_o, req_waccept_o, req_done_o, req_accept_o, oh);
            end
            next_cycle();
        end
        outport_accept_i = 1'b0;

        if (abort) begin
            req_wvalid_i = 2'b11; outport_waccept_i = 1'b1; outport_rvalid_i = 1'b1; outport_bvalid_i = 1'b1;
            rst_ni = 1'b0;
            for (int c = 0; c < 2; c++) begin
                #1;
                n_checks++;
                if (grant_o !== 2'b00 || outport_valid_o !== 1'b0 || outport_wvalid_o !== 1'b0 ||
                    req_waccept_o !== 2'b00 || req_done_o !== 2'b00 || req_accept_o !== 2'b00 ||
                    outport_addr_o !== 32'h0 || outport_len_o !== 8'h0 || outport_write_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_reset: g=%b v=%b wv=%b wa=%b d=%b acc=%b a=%h l=%0d w=%b want all 0",
                             grant_o, outport_valid_o, outport_wvalid_o, req_waccept_o, req_done_o,
                             req_accept_o, outport_addr_o, outport_len_o, outport_write_o);
                end
                next_cycle();
            end
            rst_ni = 1'b1;
            rr = 0;
            return;
        end

        if (wr_a[w]) begin
            acc = 0; guard = 0;
            while (acc < blen && guard < 3000) begin
                if (mode == 1) begin wv = 1'b1; wa = (guard < 4) ? pat[guard] : 1'b1; end
                else begin wv = 1'($urandom); wa = 1'($urandom); end
                req_wvalid_i = '0; req_wvalid_i[w] = wv; req_wvalid_i[1-w] = 1'b1;
                outport_waccept_i = wa; outport_rvalid_i = 1'($urandom); outport_bvalid_i = 1'($urandom);
                #2;
                n_checks++;
                if (outport_wvalid_o !== wv || req_waccept_o !== ((wv && wa) ? oh : 2'b00) ||
                    req_done_o !== 2'b00 || grant_o !== oh) begin
                    n_fail++;
                    $display("FAIL wdata: wv=%b wa=%b done=%b grant=%b want %b %b 00 %b beat %0d",
                             outport_wvalid_o, req_waccept_o, req_done_o, grant_o, wv,
                             (wv && wa) ? oh : 2'b00, oh, acc);
                end
                if (wv && wa) acc++;
                guard++;
                next_cycle();
            end
            n_checks++;
            if (acc != blen) begin n_fail++; $display("FAIL wdata_timeout: beats %0d want %0d", acc, blen); end
            n = (mode == 1) ? 3 : $urandom_range(0, 3);
            for (int c = 0; c <= n; c++) begin
                outport_bvalid_i = (c == n); outport_waccept_i = 1'($urandom);
                req_wvalid_i = 2'($urandom); outport_rvalid_i = 1'($urandom);
                #2;
                exp_done = (c == n) ? oh : 2'b00;
                n_checks++;
                if (req_done_o !== exp_done || outport_wvalid_o !== 1'b0 || req_waccept_o !== 2'b00 ||
                    grant_o !== oh) begin
                    n_fail++;
                    $display("FAIL wresp: done=%b wv=%b wa=%b grant=%b want %b 0 00 %b",
                             req_done_o, outport_wvalid_o, req_waccept_o, grant_o, exp_done, oh);
                end
                next_cycle();
            end
        end else begin
            acc = 0; guard = 0;
            while (acc < blen && guard < 3000) begin
                rv = (mode == 1) ? 1'b1 : 1'($urandom);
                outport_rvalid_i = rv; outport_bvalid_i = 1'($urandom);
                outport_waccept_i = 1'($urandom); req_wvalid_i = 2'($urandom);
                #2;
                if (rv) acc++;
                exp_done = (rv && acc == blen) ? oh : 2'b00;
                n_checks++;
                if (req_done_o !== exp_done || outport_wvalid_o !== 1'b0 || req_waccept_o !== 2'b00 ||
                    grant_o !== oh) begin
                    n_fail++;
                    $display("FAIL rdata: done=%b wv=%b wa=%b grant=%b want %b 0 00 %b beat %0d of %0d",
                             req_done_o, outport_wvalid_o, req_waccept_o, grant_o, exp_done, oh, acc, blen);
                end
                guard++;
                next_cycle();
            end
            n_checks++;
            if (acc != blen) begin n_fail++; $display("FAIL rdata_timeout: beats %0d want %0d", acc, blen); end
        end
        outport_rvalid_i = 1'b0; outport_bvalid_i = 1'b0; outport_waccept_i = 1'b0; req_wvalid_i = '0;
        rr = (w + 1) % 2;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_valid_i = 2'b11; req_wvalid_i = 2'b11;
        outport_accept_i = 1'b1; outport_waccept_i = 1'b1; outport_rvalid_i = 1'b1; outport_bvalid_i = 1'b1;
        rand_reqs(3);
        rr = 0;
        repeat (3) next_cycle();
        n_checks++;
        if (grant_o !== 2'b00 || req_accept_o !== 2'b00 || req_done_o !== 2'b00 || req_waccept_o !== 2'b00 ||
            outport_valid_o !== 1'b0 || outport_wvalid_o !== 1'b0 || outport_addr_o !== 32'h0 ||
            outport_len_o !== 8'h0 || outport_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: g=%b acc=%b d=%b wa=%b v=%b wv=%b a=%h l=%0d w=%b want all 0",
                     grant_o, req_accept_o, req_done_o, req_waccept_o, outport_valid_o, outport_wvalid_o,
                     outport_addr_o, outport_len_o, outport_write_o);
        end
        rst_ni = 1'b1;
        serve(2'b11, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 2; i++) begin addr_a[i] = $urandom; len_a[i] = 8'd3; wr_a[i] = 1'b0; end
        repeat (3) serve(2'b11, 1'b1, 1, 0, 1'b0);
    endtask

    task automatic test_write_pattern();
        addr_a[rr] = $urandom; len_a[rr] = 8'd2; wr_a[rr] = 1'b1;
        serve(2'b11, 1'b0, 1, 0, 1'b0);
    endtask

    task automatic test_len_bounds();
        addr_a[rr] = $urandom; len_a[rr] = 8'd0; wr_a[rr] = 1'b0;
        serve(2'b11, 1'b0, 1, 0, 1'b0);
        addr_a[rr] = $urandom; len_a[rr] = 8'd255; wr_a[rr] = 1'b0;
        serve(2'b11, 1'b0, 1, 0, 1'b0);
        addr_a[rr] = $urandom; len_a[rr] = 8'd255; wr_a[rr] = 1'b1;
        serve(2'b11, 1'b0, 0, 1, 1'b0);
    endtask

    task automatic test_accept_stall();
        rand_reqs(4);
        wr_a[rr] = 1'b1;
        serve(2'b11, 1'b0, 0, 5, 1'b0);
    endtask

    task automatic test_abort();
        addr_a[rr] = $urandom; len_a[rr] = 8'd4; wr_a[rr] = 1'b1;
        serve(2'b11, 1'b1, 1, 0, 1'b1);
        rand_reqs(3);
        serve(2'b11, 1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            rand_reqs(7);
            serve(2'($urandom_range(1, 3)), 1'($urandom), 0, -1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_write_pattern();
        test_len_bounds();
        test_accept_stall();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
